// File: rtl/scroll_pkg.sv
// Shared constants and state type for the scrolling 7-segment display controller.
package scroll_pkg;

    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam int unsigned GAP_LEN    = 4;
    localparam logic [3:0]  AN_OFF     = 4'b1111;

    typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/scroll_sequencer_tick_gen.sv
// Free-running divider with synchronous clear; tick is high for one cycle every DIV cycles.
module tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/scroll_sequencer.sv
// Scrolls a 16-entry message across a 4-digit multiplexed display.
// Optional feature macro: SCROLL_GAP_EN (four blank digits between repetitions).
module scroll_sequencer
    import scroll_pkg::*;
#(
    parameter int unsigned MSG_DEPTH = 16,
    parameter int unsigned STEP_DIV  = 100_000_000,
    parameter int unsigned SCAN_DIV  = 250_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    input  logic [4:0] len,
    input  logic       start,
    input  logic       stop,
    output logic       busy,
    output logic       wrap,
    output logic [3:0] an,
    output logic [3:0] code
);

    state_t     state;
    logic [4:0] period;
    logic [4:0] pos;
    logic [1:0] slot;
    logic [3:0] msg [MSG_DEPTH];
    logic [4:0] len_c;
    logic [5:0] raw;
    logic [3:0] cur_code;
    logic       run_clr;
    logic       step_tick;
    logic       scan_tick;
`ifdef SCROLL_GAP_EN
    logic [4:0] msg_len;
    logic [5:0] gap_idx;
`endif

    // raw never exceeds P+2, so three conditional subtractions give an exact modulo even for P=1
    function automatic logic [5:0] wrap_idx(input logic [5:0] v, input logic [4:0] p);
        logic [5:0] r;
        r = v;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r >= {1'b0, p}) r = r - {1'b0, p};
        end
        return r;
    endfunction

    assign run_clr = (state == IDLE);
    assign len_c   = (len > 5'(MSG_DEPTH)) ? 5'(MSG_DEPTH) : len;

    tick_gen #(.DIV(STEP_DIV)) u_step (
        .clk  (clk),
        .rst  (rst),
        .clr  (run_clr),
        .tick (step_tick)
    );

    tick_gen #(.DIV(SCAN_DIV)) u_scan (
        .clk  (clk),
        .rst  (rst),
        .clr  (run_clr),
        .tick (scan_tick)
    );

    always_comb begin
        raw = {1'b0, pos} + {4'b0, 2'd3 - slot};
`ifdef SCROLL_GAP_EN
        gap_idx  = wrap_idx(raw, period);
        cur_code = (gap_idx >= {1'b0, msg_len}) ? BLANK_CODE : msg[4'(gap_idx)];
`else
        cur_code = msg[4'(wrap_idx(raw, period))];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < MSG_DEPTH; i++) msg[i] <= BLANK_CODE;
        end else if (wr_en && wr_ready) begin
            msg[wr_addr] <= wr_data;
        end
    end

    // Display outputs are registered from the state of the previous cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            period   <= '0;
            pos      <= '0;
            slot     <= '0;
            an       <= AN_OFF;
            code     <= BLANK_CODE;
            busy     <= 1'b0;
            wrap     <= 1'b0;
            wr_ready <= 1'b1;
`ifdef SCROLL_GAP_EN
            msg_len  <= '0;
`endif
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    an   <= AN_OFF;
                    code <= BLANK_CODE;
                    busy <= 1'b0;
                    pos  <= '0;
                    slot <= '0;
                    if (start && len != 5'd0) begin
                        state    <= RUN;
                        wr_ready <= 1'b0;
`ifdef SCROLL_GAP_EN
                        period   <= len_c + 5'(GAP_LEN);
                        msg_len  <= len_c;
`else
                        period   <= len_c;
`endif
                    end
                end
                RUN: begin
                    busy <= 1'b1;
                    an   <= ~(4'b0001 << slot);
                    code <= cur_code;
                    if (stop) begin
                        state    <= IDLE;
                        wr_ready <= 1'b1;
                        pos      <= '0;
                        slot     <= '0;
                    end else begin
                        if (scan_tick) slot <= slot + 2'd1;
                        if (step_tick) begin
                            if (pos == period - 5'd1) begin
                                pos  <= '0;
                                wrap <= 1'b1;
                            end else begin
                                pos <= pos + 5'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scroll_sequencer.sv
// Directed and randomized bench for scroll_sequencer with an arithmetic window/scan model.
module tb_scroll_sequencer;

    localparam int unsigned STEP = 8;
    localparam int unsigned SCAN = 2;
`ifdef SCROLL_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ready;
    logic [4:0] len;
    logic       start;
    logic       stop;
    logic       busy;
    logic       wrap;
    logic [3:0] an;
    logic [3:0] code;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [3:0]  mbuf [16];
    int unsigned mL;
    int unsigned mP;
    int unsigned t;
    bit          mrun;

    scroll_sequencer #(
        .MSG_DEPTH (16),
        .STEP_DIV  (STEP),
        .SCAN_DIV  (SCAN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .len      (len),
        .start    (start),
        .stop     (stop),
        .busy     (busy),
        .wrap     (wrap),
        .an       (an),
        .code     (code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".an"}, 32'(an), 32'hF);
        chk({tag, ".code"}, 32'(code), 32'hF);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".wrap"}, 32'(wrap), 32'd0);
        chk({tag, ".wr_ready"}, 32'(wr_ready), 32'd1);
    endtask

    // Output at t cycles after the start edge reflects scan/step counts from the cycles before it
    task automatic run_cycles(input int unsigned n);
        int unsigned s, p, idx, ec;
        bit ew;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            t++;
            s   = ((t - 1) / SCAN) % 4;
            p   = ((t - 1) / STEP) % mP;
            idx = (p + 3 - s) % mP;
            ec  = (idx < mL) ? 32'(mbuf[idx]) : 32'hF;
            ew  = (t % STEP == 0) && ((t / STEP) % mP == 0);
            chk("run.an", 32'(an), 32'(15 - (1 << s)));
            chk("run.code", 32'(code), ec);
            chk("run.busy", 32'(busy), 32'd1);
            chk("run.wrap", 32'(wrap), 32'(ew));
            chk("run.wr_ready", 32'(wr_ready), 32'd0);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (!mrun) mbuf[a] = d;
    endtask

    task automatic do_start(input int unsigned ln, input bit with_stop);
        start = 1'b1;
        stop  = with_stop;
        len   = 5'(ln);
        tick();
        start = 1'b0;
        stop  = 1'b0;
        if (ln != 0) begin
            mrun = 1'b1;
            mL   = (ln > 16) ? 16 : ln;
            mP   = GAP ? mL + 4 : mL;
            t    = 0;
        end
    endtask

    task automatic do_stop(input bit with_start, input string tag);
        stop  = 1'b1;
        start = with_start;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        mrun  = 1'b0;
        tick();
        chk_idle(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        t     = 0;
        mrun  = 1'b0;
        mL    = 1;
        mP    = 1;
        for (int i = 0; i < 16; i++) mbuf[i] = 4'hF;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        len = '0;
        start = 1'b0;
        stop = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");
        tick();
        chk_idle("reset_hold");

        // Basic scroll over six characters
        for (int i = 0; i < 6; i++) do_write(4'(i), 4'(i));
        do_start(6, 1'b0);
        run_cycles(STEP * mP * 2 + 4);
        do_stop(1'b0, "stop6");

        // Two-character message repeating inside the window
        do_write(4'd0, 4'hA);
        do_write(4'd1, 4'hB);
        do_start(2, 1'b0);
        run_cycles(STEP * mP + 6);
        do_stop(1'b0, "stop2");

        // Zero length is ignored
        do_start(0, 1'b0);
        chk_idle("len0_a");
        tick();
        chk_idle("len0_b");

        // Oversized length clamps; a write during RUN must not land
        for (int i = 0; i < 16; i++) do_write(4'(i), 4'($urandom_range(0, 15)));
        do_start(20, 1'b0);
        run_cycles(5);
        wr_en = 1'b1;
        wr_addr = 4'd0;
        wr_data = ~mbuf[0];
        run_cycles(1);
        wr_en = 1'b0;
        run_cycles(STEP * mP + 20);

        // start with stop in RUN returns to IDLE
        do_stop(1'b1, "stop_start_run");

        // start with stop in IDLE enters RUN
        do_start(3, 1'b1);
        run_cycles(STEP * mP * 2 + 3);
        do_stop(1'b0, "stop3");

        // Asynchronous reset mid-run clears state and buffer
        for (int i = 0; i < 16; i++) do_write(4'(i), 4'($urandom_range(0, 14)));
        do_start(16, 1'b0);
        run_cycles(13);
        rst = 1'b1;
        #1;
        chk_idle("rst_async");
        tick();
        chk_idle("rst_hold");
        rst = 1'b0;
        mrun = 1'b0;
        for (int i = 0; i < 16; i++) mbuf[i] = 4'hF;
        tick();
        chk_idle("rst_release");
        do_start(16, 1'b0);
        run_cycles(24);
        do_stop(1'b0, "stop_after_rst");

`ifdef SCROLL_GAP_EN
        for (int i = 0; i < 4; i++) do_write(4'(i), 4'(i + 1));
        do_start(4, 1'b0);
        run_cycles(STEP * mP * 2 + 2);
        do_stop(1'b0, "stop_gap");
`endif

        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < int'($urandom_range(2, 8)); j++) begin
                do_write(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            do_start($urandom_range(1, 20), 1'b0);
            run_cycles($urandom_range(20, 150));
            do_stop(1'b0, "stop_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scroll_sequencer.md
# scroll_sequencer

Controller for the 4-digit multiplexed 7-segment display: holds a message of up to 16 character codes, steps a 4-digit window across it at a fixed scroll rate, and time-multiplexes the window onto the shared digit driver. It produces the active-low anode one-hot and the 4-bit character code for the existing seg7 decoder. Writes, start and stop come from the top-level control logic.

## Interface
- MSG_DEPTH, 16: message buffer entries; 4-bit address.
- STEP_DIV, 100_000_000: clk cycles per scroll step (1 Hz at 100 MHz).
- SCAN_DIV, 250_000: clk cycles per digit slot (400 Hz slot rate, 100 Hz frame).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  buffer write strobe; accepted when wr_en && wr_ready.
- wr_addr  in  4  buffer entry.
- wr_data  in  4  character code.
- wr_ready  out  1  high in IDLE only.
- len  in  5  message length; sampled on accepted start; values above 16 clamp to 16.
- start  in  1  begin scrolling (level, acted on in IDLE).
- stop  in  1  return to IDLE (acted on in RUN).
- busy  out  1  high in RUN.
- wrap  out  1  one-cycle pulse when the window position wraps to 0.
- an  out  4  active-low digit enables; an[0] is the rightmost digit.
- code  out  4  character code for the enabled digit.

## Operation
- States: IDLE, RUN. IDLE -> RUN on start && len!=0, latching L = min(len,16). RUN -> IDLE on stop. start with len==0 is ignored.
- IDLE: an=4'b1111, code=4'hF (blank). Scan and step counters are held at 0. Buffer writes are allowed.
- RUN: writes are ignored and wr_ready=0.
- Window slot k (k=0 leftmost, k=3 rightmost) shows buf[(pos+k) mod P], where P is the period.
- Period P = L without SCROLL_GAP_EN. The modulo is exact for every L, including L<4, where characters repeat within the window.
- Step: every STEP_DIV cycles in RUN, pos <= pos+1. When pos == P-1, pos <= 0 and wrap pulses in that same cycle.
- Scan: slot counter s (0..3) advances every SCAN_DIV cycles. an = ~(1<<s), and code = window slot 3-s, so s=0 drives the rightmost digit.
- an and code are registered and change together. There is never a cycle with two anodes low.
- stop and start asserted in the same cycle: stop wins in RUN, start wins in IDLE.
- Reset mid-operation: immediate return to IDLE with all reset values. Buffer entries reset to 4'hF.

## Timing
- Reset values: an=1111, code=F, busy=0, wrap=0, wr_ready=1, pos=0, s=0.
- Start accepted at edge N:
  - Edge N+1: busy=1, an=1110, code=buf[3 mod P].
- Scan:
  - First scan advance at edge N+1+SCAN_DIV.
  - Subsequent advances every SCAN_DIV cycles.
- Steps:
  - First step at edge N+1+STEP_DIV.
  - The updated window appears on the next scan update or the same edge, whichever comes first. The step and scan registers are combined in the same cycle.
- Stop accepted at edge M: at edge M+1, busy=0 and an=1111.
- A write accepted at edge W is readable at edge W+1.

## Configuration
- SCROLL_GAP_EN defined:
  - P = L+4.
  - Indices >= L read as blank 4'hF, so four blank digits separate repetitions and the message scrolls fully off before re-entering.
- SCROLL_GAP_EN undefined:
  - P = L; the message wraps seamlessly.
  - No gap logic is compiled.

## Structure
- Package scroll_pkg holds:
  - BLANK_CODE = 4'hF.
  - GAP_LEN = 4.
  - State enum {IDLE, RUN}.
  - Anode-off constant 4'b1111.
- Sub-module tick_gen(DIV):
  - Free-running divider with a synchronous clear; emits a one-cycle tick every DIV cycles.
  - Instantiated twice, for step and scan.
  - Held in clear while in IDLE.

## Test plan
Benches use STEP_DIV=8 and SCAN_DIV=2.
- Reset during RUN -> next cycle an=1111, code=F, busy=0; buffer reads back F.
- Write buf[0..5]=0,1,2,3,4,5; len=6; start -> frame shows slots 0,1,2,3; after 8 cycles shows 1,2,3,4; wrap pulses once, on the step from pos=5 to pos=0.
- len=2 with buf = A,B -> window A,B,A,B; after one step B,A,B,A.
- len=0 start -> stays IDLE; len=20 -> L=16, wrap every 16 steps. Without SCROLL_GAP_EN, wrap comes every 16 steps for len=20.
- Write during RUN -> buffer unchanged; start and stop together in RUN -> IDLE; start and stop together in IDLE -> RUN.
- With SCROLL_GAP_EN and len=4 (buf = 1,2,3,4) -> after 4 steps window F,F,F,F; wrap every 8 steps.
